imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Shares the single-port word-addressed instruction memory between two requesters: the core fetch port (F) and the program loader/debug port (L, read or write).
- Fetch has fixed priority. A starvation counter forces a loader grant after STARVE_MAX consecutive denials.
- Responses are registered: data or acknowledge returns exactly one cycle after the grant.
- Sits between the fetch stage / loader and the 64 x 32 instruction RAM, whose read path is combinational.

Parameters:
- AW, 32, byte-address width of both request ports.
- DEPTH, 64, number of 32-bit memory words; valid word index is 0..DEPTH-1.
- STARVE_MAX, 4, consecutive loader denials (1..15) before the loader is forced through.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- load_mode  in  1  when 1, fetch is never granted (program download)
- f_req  in  1  fetch request, held until f_gnt
- f_addr  in  AW  fetch byte address
- f_gnt  out  1  fetch granted this cycle (combinational)
- f_rvalid  out  1  fetch response valid
- f_rdata  out  32  fetch instruction word
- f_err  out  1  fetch response error (qualified by f_rvalid)
- l_req  in  1  loader request, held until l_gnt
- l_we  in  1  loader write enable
- l_addr  in  AW  loader byte address
- l_wdata  in  32  loader write data
- l_gnt  out  1  loader granted this cycle (combinational)
- l_rvalid  out  1  loader response/ack valid
- l_rdata  out  32  loader read data (0 for writes)
- l_err  out  1  loader response error
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  $clog2(DEPTH)  word index (byte address [..:2])
- mem_wdata  out  32  write data
- mem_rdata  in  32  combinational read data for mem_addr

Behaviour:
- Reset (rst_n=0, asynchronous): state=FETCH_PRI; starve_cnt=0; all rvalid, err and rdata = 0.
  - Grants are combinational and forced to 0 while rst_n=0.
- At most one grant per cycle. A requester deasserts or changes its request only after its grant.
- FSM states and grant rules:
  - FETCH_PRI: f_gnt = f_req & ~load_mode; l_gnt = l_req & ~f_gnt.
  - LOAD_FORCE: l_gnt = l_req; f_gnt = f_req & ~l_req & ~load_mode.
  - FETCH_PRI -> LOAD_FORCE when l_req & ~l_gnt and starve_cnt == STARVE_MAX-1.
  - LOAD_FORCE -> FETCH_PRI on the cycle l_gnt=1, or when l_req drops.
- starve_cnt:
  - Increments when l_req & ~l_gnt in FETCH_PRI.
  - Clears on any l_gnt, on !l_req, or on entering LOAD_FORCE.
  - Never wraps: saturates at STARVE_MAX-1.
- Error check: err = (addr[1:0] != 0) or (addr[AW-1:2] >= DEPTH).
  - On an error grant: mem_en=0, mem_we=0, and no write occurs.
  - Response next cycle: rvalid=1, err=1, rdata=0.
- Memory drive on a legal grant: mem_en=1, mem_addr = granted addr[..:2], mem_we = l_gnt & l_we, mem_wdata = l_wdata.
  - With no grant, all mem_* outputs = 0.
- Latency: 1 cycle.
  - The cycle after a grant, that port's rvalid=1 for exactly one cycle.
  - Read: rdata = mem_rdata captured at the grant edge.
  - Write: rdata = 0, err = 0.
  - The non-granted port's rvalid = 0.
- Back-to-back grants to the same port give rvalid on consecutive cycles.
- Simultaneous requests: resolved by the FSM rules above, never both granted.
- load_mode rising mid-stream: an already-registered fetch response is still delivered; no new f_gnt is issued.
- Reset mid-operation: the pending response is dropped (rvalid=0) and no memory write is issued.

Optional Feature:
- Macro IMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs f_grant_cnt[15:0], l_grant_cnt[15:0] and force_cnt[7:0].
  - These count grants per port and FETCH_PRI->LOAD_FORCE transitions; they wrap modulo width and are reset to 0.
- Undefined: those ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package imem_arb_pkg:
  - arb_state_t enum {FETCH_PRI, LOAD_FORCE}.
  - WORD_BYTES=4.
  - Function addr_err(addr, depth).
- One sub-module, imem_arb_rsp_reg: the per-port response register (rvalid/rdata/err), instantiated twice.

Test Plan:
- Reset release, only f_req=1, f_addr=0x8 -> f_gnt same cycle, mem_addr=2; next cycle f_rvalid=1, f_rdata=mem[2], f_err=0.
- f_req held high every cycle plus l_req=1, STARVE_MAX=4:
  - l_gnt=0 for 4 cycles, then l_gnt=1 in the 5th cycle with f_gnt=0 that cycle.
  - FSM returns to FETCH_PRI; starve_cnt=0.
- load_mode=1, f_req=1, l_req=1 l_we=1 l_addr=0x10 l_wdata=0xDEADBEEF -> l_gnt=1, mem_we=1, mem_addr=4; next cycle l_rvalid=1, l_rdata=0; later fetch of 0x10 returns 0xDEADBEEF.
- l_req write to l_addr=0x102 (misaligned) and to 0x100 (index 64 = DEPTH) -> mem_en=0, no write; l_rvalid=1, l_err=1 next cycle; memory contents unchanged.
- Back-to-back fetches 0x0, 0x4, 0x8 -> f_rvalid on 3 consecutive cycles with words 0, 1, 2 in order.
- rst_n pulsed low between a grant and its response -> rvalid stays 0, all outputs 0 immediately; after release, normal operation resumes from FETCH_PRI.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
// Holds the FSM state type, word size and the address-legality check.
package imem_arb_pkg;

  typedef enum logic [0:0] {
    FETCH_PRI  = 1'b0,
    LOAD_FORCE = 1'b1
  } arb_state_t;

  localparam int unsigned WORD_BYTES = 4;

  // True when a byte address is not word aligned or is past the last word.
  function automatic logic addr_err(
    input logic [63:0] addr,
    input int unsigned depth
  );
    logic [63:0] idx;
    idx = addr / 64'(WORD_BYTES);
    return (addr[1:0] != 2'b00) || (idx >= 64'(depth));
  endfunction

endpackage

// File: rtl/imem_arb_if.sv
// Bus bundle between fetch/loader requesters, the arbiter and the RAM.
// Modports: slave = arbiter side, master = requesters + RAM side.
interface imem_arb_if #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DEPTH = 64
);
  localparam int unsigned IW = $clog2(DEPTH);

  logic          load_mode;
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [31:0]   f_rdata;
  logic          f_err;
  logic          l_req;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [31:0]   l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [31:0]   l_rdata;
  logic          l_err;
  logic          mem_en;
  logic          mem_we;
  logic [IW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  load_mode, f_req, f_addr,
    input  l_req, l_we, l_addr, l_wdata,
    input  mem_rdata,
    output f_gnt, f_rvalid, f_rdata, f_err,
    output l_gnt, l_rvalid, l_rdata, l_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output load_mode, f_req, f_addr,
    output l_req, l_we, l_addr, l_wdata,
    output mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_err,
    input  l_gnt, l_rvalid, l_rdata, l_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_arb_rsp_reg.sv
// One-cycle response register for a single arbiter port.
// Ports: gnt/err/we of the grant cycle + read data in; rvalid/rdata/err out.
module imem_arb_rsp_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gnt_i,
  input  logic        err_i,
  input  logic        we_i,
  input  logic [31:0] rdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    rvalid_d = gnt_i;
    err_d    = gnt_i & err_i;
    rdata_d  = (gnt_i & ~err_i & ~we_i) ? rdata_i : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: rtl/imem_arbiter.sv
// Fetch/loader arbiter for the single-port instruction RAM.
// Ports: clk, rst_n, bus (imem_arb_if.slave); with IMEM_ARB_STATS_EN also grant/force counters.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef IMEM_ARB_STATS_EN
  output logic [15:0] f_grant_cnt_o,
  output logic [15:0] l_grant_cnt_o,
  output logic [7:0]  force_cnt_o,
`endif
  imem_arb_if.slave   bus
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam logic [3:0] CNT_TOP = 4'(STARVE_MAX - 1);

  arb_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       f_gnt, l_gnt;
  logic       f_bad, l_bad;
  logic       legal;
  logic       to_force;

  assign f_bad = addr_err({{(64-AW){1'b0}}, bus.f_addr}, DEPTH);
  assign l_bad = addr_err({{(64-AW){1'b0}}, bus.l_addr}, DEPTH);

  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        FETCH_PRI: begin
          f_gnt = bus.f_req & ~bus.load_mode;
          l_gnt = bus.l_req & ~f_gnt;
        end
        LOAD_FORCE: begin
          l_gnt = bus.l_req;
          f_gnt = bus.f_req & ~bus.l_req & ~bus.load_mode;
        end
      endcase
    end
  end

  // Denials only reach CNT_TOP, where the FSM leaves, so cnt never wraps.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    to_force = 1'b0;
    unique case (state_q)
      FETCH_PRI: begin
        if (l_gnt || !bus.l_req) begin
          cnt_d = '0;
        end else if (cnt_q >= CNT_TOP) begin
          state_d  = LOAD_FORCE;
          cnt_d    = '0;
          to_force = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      LOAD_FORCE: begin
        cnt_d = '0;
        if (l_gnt || !bus.l_req) state_d = FETCH_PRI;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_PRI;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.f_gnt = f_gnt;
  assign bus.l_gnt = l_gnt;

  assign legal = (f_gnt & ~f_bad) | (l_gnt & ~l_bad);

  always_comb begin
    bus.mem_en    = legal;
    bus.mem_we    = legal & l_gnt & bus.l_we;
    bus.mem_wdata = legal ? bus.l_wdata : '0;
    bus.mem_addr  = '0;
    if (legal)
      bus.mem_addr = f_gnt ? bus.f_addr[IW+1:2]
                           : bus.l_addr[IW+1:2];
  end

  imem_arb_rsp_reg u_f_rsp (
    .clk      (clk),
    .rst_n    (rst_n),
    .gnt_i    (f_gnt),
    .err_i    (f_bad),
    .we_i     (1'b0),
    .rdata_i  (bus.mem_rdata),
    .rvalid_o (bus.f_rvalid),
    .rdata_o  (bus.f_rdata),
    .err_o    (bus.f_err)
  );

  imem_arb_rsp_reg u_l_rsp (
    .clk      (clk),
    .rst_n    (rst_n),
    .gnt_i    (l_gnt),
    .err_i    (l_bad),
    .we_i     (bus.l_we),
    .rdata_i  (bus.mem_rdata),
    .rvalid_o (bus.l_rvalid),
    .rdata_o  (bus.l_rdata),
    .err_o    (bus.l_err)
  );

`ifdef IMEM_ARB_STATS_EN
  logic [15:0] fcnt_q, lcnt_q;
  logic [7:0]  xcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      lcnt_q <= '0;
      xcnt_q <= '0;
    end else begin
      if (f_gnt)    fcnt_q <= fcnt_q + 16'd1;
      if (l_gnt)    lcnt_q <= lcnt_q + 16'd1;
      if (to_force) xcnt_q <= xcnt_q + 8'd1;
    end
  end

  assign f_grant_cnt_o = fcnt_q;
  assign l_grant_cnt_o = lcnt_q;
  assign force_cnt_o   = xcnt_q;
`else
  logic unused_force;
  assign unused_force = to_force;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a 64-word behavioural RAM.
// Each comparison is an immediate assertion; a summary line ends the run.
module tb_imem_arbiter;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;

  logic [31:0] mem [64];

  imem_arb_if #(.AW(32), .DEPTH(64)) bus ();

`ifdef IMEM_ARB_STATS_EN
  logic [15:0] f_grant_cnt;
  logic [15:0] l_grant_cnt;
  logic [7:0]  force_cnt;
`endif

  imem_arbiter #(
    .AW         (32),
    .DEPTH      (64),
    .STARVE_MAX (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef IMEM_ARB_STATS_EN
    .f_grant_cnt_o (f_grant_cnt),
    .l_grant_cnt_o (l_grant_cnt),
    .force_cnt_o   (force_cnt),
`endif
    .bus           (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    rst_n         = 1'b0;
    bus.load_mode = 1'b0;
    bus.f_req     = 1'b1;
    bus.f_addr    = 32'h0;
    bus.l_req     = 1'b1;
    bus.l_we      = 1'b0;
    bus.l_addr    = 32'h0;
    bus.l_wdata   = 32'h0;
    #1;
    chk("rst_f_gnt", 32'(bus.f_gnt), 32'd0);
    chk("rst_l_gnt", 32'(bus.l_gnt), 32'd0);
    chk("rst_f_rvalid", 32'(bus.f_rvalid), 32'd0);
    chk("rst_l_rvalid", 32'(bus.l_rvalid), 32'd0);
    chk("rst_f_rdata", bus.f_rdata, 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    step();
    step();

    // single fetch after reset release
    rst_n      = 1'b1;
    bus.l_req  = 1'b0;
    bus.f_addr = 32'h8;
    #1;
    chk("f1_gnt", 32'(bus.f_gnt), 32'd1);
    chk("f1_l_gnt", 32'(bus.l_gnt), 32'd0);
    chk("f1_mem_en", 32'(bus.mem_en), 32'd1);
    chk("f1_mem_addr", 32'(bus.mem_addr), 32'd2);
    step();
    bus.f_req = 1'b0;
    chk("f1_rvalid", 32'(bus.f_rvalid), 32'd1);
    chk("f1_rdata", bus.f_rdata, 32'hC0DE_0002);
    chk("f1_err", 32'(bus.f_err), 32'd0);
    chk("f1_l_rvalid", 32'(bus.l_rvalid), 32'd0);

    // starvation: two full rounds of 4 denials then a forced grant
    bus.f_req  = 1'b1;
    bus.f_addr = 32'h0;
    bus.l_req  = 1'b1;
    bus.l_we   = 1'b0;
    bus.l_addr = 32'hC;
    #1;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        chk("stv_f_gnt", 32'(bus.f_gnt), 32'd1);
        chk("stv_l_gnt", 32'(bus.l_gnt), 32'd0);
        if (r == 1 && c == 0) begin
          chk("stv_l_rvalid", 32'(bus.l_rvalid), 32'd1);
          chk("stv_l_rdata", bus.l_rdata, 32'hC0DE_0003);
          chk("stv_f_rvalid0", 32'(bus.f_rvalid), 32'd0);
        end
        step();
      end
      chk("frc_l_gnt", 32'(bus.l_gnt), 32'd1);
      chk("frc_f_gnt", 32'(bus.f_gnt), 32'd0);
      chk("frc_mem_addr", 32'(bus.mem_addr), 32'd3);
      step();
    end
    bus.l_req = 1'b0;
    bus.f_req = 1'b0;
    chk("frc2_l_rvalid", 32'(bus.l_rvalid), 32'd1);

    // load_mode write, then fetch it back
    bus.load_mode = 1'b1;
    bus.f_req     = 1'b1;
    bus.f_addr    = 32'h10;
    bus.l_req     = 1'b1;
    bus.l_we      = 1'b1;
    bus.l_addr    = 32'h10;
    bus.l_wdata   = 32'hDEAD_BEEF;
    #1;
    chk("lm_l_gnt", 32'(bus.l_gnt), 32'd1);
    chk("lm_f_gnt", 32'(bus.f_gnt), 32'd0);
    chk("lm_mem_we", 32'(bus.mem_we), 32'd1);
    chk("lm_mem_addr", 32'(bus.mem_addr), 32'd4);
    chk("lm_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    step();
    bus.l_req = 1'b0;
    chk("lm_l_rvalid", 32'(bus.l_rvalid), 32'd1);
    chk("lm_l_rdata", bus.l_rdata, 32'd0);
    chk("lm_l_err", 32'(bus.l_err), 32'd0);
    #1;
    chk("lm_f_blocked", 32'(bus.f_gnt), 32'd0);
    bus.load_mode = 1'b0;
    #1;
    chk("rb_f_gnt", 32'(bus.f_gnt), 32'd1);
    chk("rb_mem_addr", 32'(bus.mem_addr), 32'd4);
    step();
    bus.f_req = 1'b0;
    chk("rb_f_rdata", bus.f_rdata, 32'hDEAD_BEEF);

    // illegal loader writes: misaligned, then index == DEPTH
    bus.l_req   = 1'b1;
    bus.l_we    = 1'b1;
    bus.l_addr  = 32'h102;
    bus.l_wdata = 32'h1111_1111;
    #1;
    chk("mis_l_gnt", 32'(bus.l_gnt), 32'd1);
    chk("mis_mem_en", 32'(bus.mem_en), 32'd0);
    chk("mis_mem_we", 32'(bus.mem_we), 32'd0);
    step();
    bus.l_addr = 32'h100;
    chk("mis_l_rvalid", 32'(bus.l_rvalid), 32'd1);
    chk("mis_l_err", 32'(bus.l_err), 32'd1);
    chk("mis_l_rdata", bus.l_rdata, 32'd0);
    #1;
    chk("oob_l_gnt", 32'(bus.l_gnt), 32'd1);
    chk("oob_mem_en", 32'(bus.mem_en), 32'd0);
    step();
    bus.l_req = 1'b0;
    bus.l_we  = 1'b0;
    chk("oob_l_rvalid", 32'(bus.l_rvalid), 32'd1);
    chk("oob_l_err", 32'(bus.l_err), 32'd1);

    // misaligned fetch
    bus.f_req  = 1'b1;
    bus.f_addr = 32'h101;
    #1;
    chk("fe_f_gnt", 32'(bus.f_gnt), 32'd1);
    chk("fe_mem_en", 32'(bus.mem_en), 32'd0);
    step();
    bus.f_req = 1'b0;
    chk("fe_rvalid", 32'(bus.f_rvalid), 32'd1);
    chk("fe_err", 32'(bus.f_err), 32'd1);
    chk("fe_rdata", bus.f_rdata, 32'd0);

    // back-to-back fetches 0x0, 0x4, 0x8
    bus.f_req  = 1'b1;
    bus.f_addr = 32'h0;
    #1;
    chk("bb_gnt", 32'(bus.f_gnt), 32'd1);
    step();
    bus.f_addr = 32'h4;
    chk("bb0_rvalid", 32'(bus.f_rvalid), 32'd1);
    chk("bb0_rdata", bus.f_rdata, 32'hC0DE_0000);
    step();
    bus.f_addr = 32'h8;
    chk("bb1_rvalid", 32'(bus.f_rvalid), 32'd1);
    chk("bb1_rdata", bus.f_rdata, 32'hC0DE_0001);
    step();
    bus.f_req = 1'b0;
    chk("bb2_rvalid", 32'(bus.f_rvalid), 32'd1);
    chk("bb2_rdata", bus.f_rdata, 32'hC0DE_0002);
    step();
    chk("bb_idle_rvalid", 32'(bus.f_rvalid), 32'd0);

    // reset between a grant and its response
    bus.f_req  = 1'b1;
    bus.f_addr = 32'hC;
    #1;
    chk("rm_f_gnt", 32'(bus.f_gnt), 32'd1);
    rst_n       = 1'b0;
    bus.l_req   = 1'b1;
    bus.l_we    = 1'b1;
    bus.l_addr  = 32'h14;
    bus.l_wdata = 32'h2222_2222;
    #1;
    chk("rm_f_gnt0", 32'(bus.f_gnt), 32'd0);
    chk("rm_l_gnt0", 32'(bus.l_gnt), 32'd0);
    chk("rm_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rm_mem_we", 32'(bus.mem_we), 32'd0);
    step();
    chk("rm_f_rvalid", 32'(bus.f_rvalid), 32'd0);
    chk("rm_l_rvalid", 32'(bus.l_rvalid), 32'd0);
    rst_n      = 1'b1;
    bus.l_req  = 1'b0;
    bus.l_we   = 1'b0;
    bus.f_addr = 32'h14;
    #1;
    chk("rr_f_gnt", 32'(bus.f_gnt), 32'd1);
    chk("rr_mem_addr", 32'(bus.mem_addr), 32'd5);
    step();
    bus.f_req = 1'b0;
    chk("rr_f_rvalid", 32'(bus.f_rvalid), 32'd1);
    chk("rr_f_rdata", bus.f_rdata, 32'hC0DE_0005);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
